// File: rtl/mem_access.sv
// Memory-access pipeline stage: aligns/validates loads and stores, drives a
// single-outstanding data-RAM request and formats returned load data.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        exc_in,
  input  logic        mem_read_flag,
  input  logic        mem_write_flag,
  input  logic        mem_sign_ext_flag,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_write_data,
  input  logic [31:0] result_in,
  input  logic        reg_write_en_in,
  input  logic [4:0]  reg_write_addr_in,
  output logic [31:0] result_out,
  output logic        reg_write_en_out,
  output logic [4:0]  reg_write_addr_out,
  output logic        stall_request,
  output logic        adel,
  output logic        ades,
  output logic [31:0] bad_vaddr,
  output logic        ram_en,
  output logic [3:0]  ram_write_en,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_write_data,
  input  logic [31:0] ram_read_data,
  input  logic        ram_ready,
  output logic [1:0]  fsm_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]  state;
  logic [31:0] rdata_q;
  logic        mem_op;
  logic        misaligned;
  logic        addr_err;
  logic        access;
  logic [3:0]  strobe;
  logic [31:0] store_data;
  logic [31:0] lane;
  logic [31:0] load_data;

  assign fsm_state  = state;
  assign mem_op     = mem_read_flag | mem_write_flag;
  assign misaligned = ((mem_sel == 4'b0011) & result_in[0]) |
                      ((mem_sel == 4'b1111) & (result_in[1:0] != 2'b00));
  // Address faults are only raised when the instruction is first evaluated.
  assign addr_err   = (state == IDLE) & mem_op & misaligned & ~exc_in;
  assign access     = (state == IDLE) & mem_op & ~exc_in & ~flush & ~misaligned;
  assign strobe     = mem_sel << result_in[1:0];
  assign lane       = rdata_q >> {result_in[1:0], 3'b000};

  assign adel               = addr_err & mem_read_flag;
  assign ades               = addr_err & mem_write_flag;
  assign bad_vaddr          = addr_err ? result_in : 32'd0;
  assign reg_write_en_out   = reg_write_en_in & ~flush & ~addr_err;
  assign reg_write_addr_out = reg_write_addr_in;
  assign result_out         = ((state == DONE) && mem_read_flag) ? load_data : result_in;

  always_comb begin
    store_data = mem_write_data;
    case (mem_sel)
      4'b0001: store_data = {4{mem_write_data[7:0]}};
      4'b0011: store_data = {2{mem_write_data[15:0]}};
      default: store_data = mem_write_data;
    endcase
  end

  always_comb begin
    load_data = rdata_q;
    case (mem_sel)
      4'b0001: load_data = mem_sign_ext_flag ? {{24{lane[7]}}, lane[7:0]}
                                             : {24'd0, lane[7:0]};
      4'b0011: load_data = mem_sign_ext_flag ? {{16{lane[15]}}, lane[15:0]}
                                             : {16'd0, lane[15:0]};
      default: load_data = rdata_q;
    endcase
  end

  always_comb begin
    stall_request = 1'b0;
    case (state)
      IDLE:    stall_request = access;
      REQ:     stall_request = 1'b1;
      DONE:    stall_request = 1'b0;
      DRAIN:   stall_request = mem_op;
      default: stall_request = 1'b0;
    endcase
  end

  // RAM handshake: ram_en is the valid; address/strobes/data stay frozen while
  // it is high and the transfer completes in the cycle ram_ready is high.
  // ram_en drops without ram_ready only when rst abandons the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      ram_en         <= 1'b0;
      ram_write_en   <= 4'd0;
      ram_addr       <= 32'd0;
      ram_write_data <= 32'd0;
      rdata_q        <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            ram_en         <= 1'b1;
            ram_addr       <= {result_in[31:2], 2'b00};
            ram_write_en   <= mem_write_flag ? strobe : 4'd0;
            ram_write_data <= store_data;
            state          <= REQ;
          end
        end
        REQ: begin
          if (ram_ready) begin
            ram_en <= 1'b0;
            if (flush) begin
              state <= IDLE;
            end else begin
              rdata_q <= ram_read_data;
              state   <= DONE;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DONE: state <= IDLE;
        DRAIN: begin
          if (ram_ready) begin
            ram_en <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed scenarios plus randomized traffic checked every
// cycle against a transaction-level model with a shadow memory.
module tb_mem_access;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        exc_in;
  logic        mem_read_flag;
  logic        mem_write_flag;
  logic        mem_sign_ext_flag;
  logic [3:0]  mem_sel;
  logic [31:0] mem_write_data;
  logic [31:0] result_in;
  logic        reg_write_en_in;
  logic [4:0]  reg_write_addr_in;
  logic [31:0] result_out;
  logic        reg_write_en_out;
  logic [4:0]  reg_write_addr_out;
  logic        stall_request;
  logic        adel;
  logic        ades;
  logic [31:0] bad_vaddr;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        ram_ready;
  logic [1:0]  fsm_state;

  mem_access dut (
    .clk(clk), .rst(rst), .flush(flush), .exc_in(exc_in),
    .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
    .mem_sign_ext_flag(mem_sign_ext_flag), .mem_sel(mem_sel),
    .mem_write_data(mem_write_data), .result_in(result_in),
    .reg_write_en_in(reg_write_en_in), .reg_write_addr_in(reg_write_addr_in),
    .result_out(result_out), .reg_write_en_out(reg_write_en_out),
    .reg_write_addr_out(reg_write_addr_out), .stall_request(stall_request),
    .adel(adel), .ades(ades), .bad_vaddr(bad_vaddr),
    .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
    .ram_ready(ram_ready), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- RAM model (stimulus side) ----------------
  logic [31:0] mem [16];
  int wait_cnt    = 0;
  int wait_target = 0;
  int force_wait  = -1;

  // ---------------- reference model ----------------
  logic [31:0] exp_mem [16];
  logic [31:0] exp_q[$];
  bit          m_busy, m_drop, m_done, m_done_load;
  logic [31:0] m_addr, m_wd;
  logic [3:0]  m_we;
  int          m_off, m_size;
  bit          m_sx;
  bit          m_acc_s, m_stall_s;

  // snapshot of DUT outputs in the last checked cycle
  logic [31:0] s_res, s_addr, s_wd, s_bad;
  logic [3:0]  s_we;
  logic        s_stall, s_en, s_adel, s_rwe;

  function automatic int sz(logic [3:0] sel);
    if (sel == 4'b0001) return 1;
    if (sel == 4'b0011) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] fmt(logic [31:0] w, int off, int size, bit sx);
    logic [31:0] v;
    v = w >> (8 * off);
    if (size == 1) begin
      v = v & 32'hFF;
      if (sx && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (size == 2) begin
      v = v & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_drop = 0; m_done = 0; m_done_load = 0;
    m_addr = 0; m_we = 0; m_wd = 0; m_off = 0; m_size = 4; m_sx = 0;
    exp_q.delete();
  endtask

  task automatic ram_respond();
    if (ram_en) begin
      ram_read_data = mem[ram_addr[5:2]];
      if (wait_cnt == 0) force_wait = -1;
      ram_ready = (wait_cnt == wait_target);
      if (ram_ready) begin
        for (int b = 0; b < 4; b++)
          if (ram_write_en[b]) mem[ram_addr[5:2]][8*b +: 8] = ram_write_data[8*b +: 8];
      end
      wait_cnt++;
    end else begin
      ram_ready     = 1'b0;
      ram_read_data = $urandom;
      wait_cnt      = 0;
      wait_target   = (force_wait >= 0) ? force_wait : $urandom_range(0, 3);
    end
  endtask

  task automatic compare();
    bit          idle, mop, mis, err;
    int          size;
    logic [31:0] e_res;
    idle = !m_busy && !m_done;
    mop  = mem_read_flag || mem_write_flag;
    size = sz(mem_sel);
    mis  = (result_in % size) != 0;
    err  = idle && mop && mis && !exc_in;
    m_acc_s   = idle && mop && !exc_in && !flush && !mis;
    m_stall_s = m_acc_s || (m_busy && !m_drop) || (m_busy && m_drop && mop);
    e_res = (m_done && m_done_load && exp_q.size() > 0) ? exp_q[0] : result_in;
    chk("result_out", result_out, e_res);
    chk("reg_write_en_out", {31'd0, reg_write_en_out}, {31'd0, reg_write_en_in && !flush && !err});
    chk("reg_write_addr_out", {27'd0, reg_write_addr_out}, {27'd0, reg_write_addr_in});
    chk("stall_request", {31'd0, stall_request}, {31'd0, m_stall_s});
    chk("adel", {31'd0, adel}, {31'd0, err && mem_read_flag});
    chk("ades", {31'd0, ades}, {31'd0, err && mem_write_flag});
    chk("bad_vaddr", bad_vaddr, err ? result_in : 32'd0);
    chk("ram_en", {31'd0, ram_en}, {31'd0, m_busy});
    chk("ram_write_en", {28'd0, ram_write_en}, {28'd0, m_we});
    chk("ram_addr", ram_addr, m_addr);
    chk("ram_write_data", ram_write_data, m_wd);
    s_res = result_out; s_addr = ram_addr; s_wd = ram_write_data; s_bad = bad_vaddr;
    s_we = ram_write_en; s_stall = stall_request; s_en = ram_en; s_adel = adel;
    s_rwe = reg_write_en_out;
  endtask

  task automatic model_update();
    if (m_busy && ram_ready) begin
      for (int b = 0; b < 4; b++)
        if (m_we[b]) exp_mem[m_addr[5:2]][8*b +: 8] = m_wd[8*b +: 8];
    end
    if (rst) begin
      model_reset();
    end else if (m_busy) begin
      if (ram_ready) begin
        m_busy = 0;
        if (!m_drop && !flush) begin
          m_done      = 1;
          m_done_load = (m_we == 4'd0);
          if (m_done_load) exp_q.push_back(fmt(exp_mem[m_addr[5:2]], m_off, m_size, m_sx));
        end
        m_drop = 0;
      end else if (flush) begin
        m_drop = 1;
      end
    end else if (m_done) begin
      m_done = 0;
      if (m_done_load && exp_q.size() > 0) void'(exp_q.pop_front());
      m_done_load = 0;
    end else if (m_acc_s) begin
      m_busy = 1;
      m_off  = int'(result_in & 32'd3);
      m_size = sz(mem_sel);
      m_sx   = mem_sign_ext_flag;
      m_addr = result_in - 32'(m_off);
      m_we   = 4'd0;
      if (mem_write_flag)
        for (int b = 0; b < m_size; b++) m_we[m_off + b] = 1'b1;
      if (m_size == 1)      m_wd = (mem_write_data & 32'hFF) * 32'h0101_0101;
      else if (m_size == 2) m_wd = (mem_write_data & 32'hFFFF) * 32'h0001_0001;
      else                  m_wd = mem_write_data;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    ram_respond();
    #2;
    compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_op(bit rd, bit wr, logic [3:0] sel, bit sx,
                        logic [31:0] addr, logic [31:0] wdata);
    mem_read_flag = rd; mem_write_flag = wr; mem_sel = sel; mem_sign_ext_flag = sx;
    result_in = addr; mem_write_data = wdata; reg_write_en_in = 1'b1;
    reg_write_addr_in = 5'd7; exc_in = 1'b0;
  endtask

  int          stalls;
  bit          got_en;
  logic [31:0] f_addr, f_wd;
  logic [3:0]  f_we;

  task automatic run_op();
    bit fin;
    fin = 0; stalls = 0; got_en = 0;
    for (int c = 0; c < 24 && !fin; c++) begin
      step();
      if (s_en && !got_en) begin
        got_en = 1; f_addr = s_addr; f_we = s_we; f_wd = s_wd;
      end
      if (s_stall) stalls++;
      if (!m_stall_s) fin = 1;
    end
    if (!fin) chk("run_op_timeout", 32'd1, 32'd0);
  endtask

  task automatic new_instr();
    int   op, k;
    logic [3:0] sel;
    op = $urandom_range(0, 2);
    k  = $urandom_range(0, 2);
    sel = (k == 0) ? 4'b0001 : (k == 1) ? 4'b0011 : 4'b1111;
    result_in = 32'h1000 + 32'($urandom_range(0, 63));
    if ($urandom_range(0, 3) != 0) result_in = result_in & ~(32'(sz(sel)) - 32'd1);
    mem_read_flag     = (op == 1);
    mem_write_flag    = (op == 2);
    mem_sel           = sel;
    mem_sign_ext_flag = $urandom_range(0, 1) == 1;
    mem_write_data    = $urandom;
    reg_write_en_in   = $urandom_range(0, 1) == 1;
    reg_write_addr_in = 5'($urandom_range(0, 31));
    exc_in            = ($urandom_range(0, 9) == 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; ram_ready = 1'b0; ram_read_data = 32'd0;
    set_op(0, 0, 4'b1111, 0, 32'h0000_1234, 32'd0);
    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      exp_mem[i] = mem[i];
    end
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // reset state
    step();
    chk("rst_ram_en", {31'd0, s_en}, 32'd0);
    chk("rst_ram_addr", s_addr, 32'd0);
    chk("rst_stall", {31'd0, s_stall}, 32'd0);
    chk("rst_result_pass", s_res, 32'h0000_1234);

    // signed byte load with two RAM wait cycles
    mem[0] = 32'h80FF_1234; exp_mem[0] = 32'h80FF_1234;
    force_wait = 2;
    set_op(1, 0, 4'b0001, 1, 32'h0000_1003, 32'd0);
    run_op();
    chk("byte_load_result", s_res, 32'hFFFF_FF80);
    chk("byte_load_stall_cycles", 32'(stalls), 32'd4);

    // half store lane steering and replication
    set_op(0, 1, 4'b0011, 0, 32'h0000_2002, 32'h0000_ABCD);
    run_op();
    chk("half_store_we", {28'd0, f_we}, 32'h0000_000C);
    chk("half_store_wdata", f_wd, 32'hABCD_ABCD);
    chk("half_store_addr", f_addr, 32'h0000_2000);

    // misaligned word load
    set_op(1, 0, 4'b1111, 0, 32'h0000_3001, 32'd0);
    step();
    chk("misalign_adel", {31'd0, s_adel}, 32'd1);
    chk("misalign_bad_vaddr", s_bad, 32'h0000_3001);
    chk("misalign_stall", {31'd0, s_stall}, 32'd0);
    chk("misalign_reg_we", {31'd0, s_rwe}, 32'd0);
    set_op(0, 0, 4'b1111, 0, 32'h0000_0010, 32'd0);
    step();
    chk("misalign_no_ram_en", {31'd0, s_en}, 32'd0);

    // flush during REQ, then a load waiting behind the drain
    mem[2] = 32'h1234_5678; exp_mem[2] = 32'h1234_5678;
    force_wait = 3;
    set_op(1, 0, 4'b1111, 0, 32'h0000_1004, 32'd0);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    set_op(1, 0, 4'b1111, 0, 32'h0000_1008, 32'd0);
    step();
    chk("drain_stall", {31'd0, s_stall}, 32'd1);
    chk("drain_ram_en", {31'd0, s_en}, 32'd1);
    run_op();
    chk("after_drain_load", s_res, 32'h1234_5678);

    // reset in the middle of a request
    force_wait = 3;
    set_op(1, 0, 4'b1111, 0, 32'h0000_100C, 32'd0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_op(0, 0, 4'b1111, 0, 32'h0000_0020, 32'd0);
    step();
    chk("rst_req_ram_en", {31'd0, s_en}, 32'd0);
    chk("rst_req_stall", {31'd0, s_stall}, 32'd0);

    // load suppressed by an upstream exception
    set_op(1, 0, 4'b1111, 0, 32'h0000_4444, 32'd0);
    exc_in = 1'b1;
    step();
    chk("exc_stall", {31'd0, s_stall}, 32'd0);
    chk("exc_result_pass", s_res, 32'h0000_4444);
    exc_in = 1'b0;

    // randomized traffic
    new_instr();
    for (int c = 0; c < 3000; c++) begin
      flush = ($urandom_range(0, 11) == 0);
      rst   = ($urandom_range(0, 199) == 0);
      step();
      if (!m_stall_s || flush || rst) new_instr();
    end
    flush = 1'b0; rst = 1'b0;
    set_op(0, 0, 4'b1111, 0, 32'h0000_0000, 32'd0);
    repeat (8) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
